// File: rtl/timeout_timer.sv
// timeout_timer: tick-driven countdown timer for the code-lock datapath.
// Loads a tick count on start, decrements it on each prescaler strobe (ce)
// while running, and pulses done for one cycle when the count expires.
// Optional feature macro: TIMEOUT_TIMER_PERIODIC_EN
//   defined   -> on expiry the counter reloads and the timer keeps running
//   undefined -> one-shot, the timer returns to IDLE on expiry
// Per-cycle priority: clr > abort > start > ce.
module timeout_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic             busy_r;
  logic             done_r;
  logic             load_zero_s;
  logic             last_tick_s;

`ifdef TIMEOUT_TIMER_PERIODIC_EN
  logic [WIDTH-1:0] reload_r;
`endif

  // Decode the zero-length load and the terminal count.
  always_comb begin
    load_zero_s = (load_val == {WIDTH{1'b0}});
    last_tick_s = (count_r == {{(WIDTH-1){1'b0}}, 1'b1});
  end

  // Timer FSM: state, counter, reload value and registered busy/done.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
      count_r <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef TIMEOUT_TIMER_PERIODIC_EN
      reload_r <= {WIDTH{1'b0}};
`endif
    end else begin
      // done is a single-cycle pulse unless re-asserted below.
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (abort) begin
            // Nothing to stop; hold the idle values.
            state_r <= IDLE;
            count_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
          end else if (start) begin
            if (load_zero_s) begin
              // Zero-length timeout: expire immediately without running.
              state_r <= IDLE;
              count_r <= {WIDTH{1'b0}};
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
              count_r <= load_val;
              busy_r  <= 1'b1;
`ifdef TIMEOUT_TIMER_PERIODIC_EN
              reload_r <= load_val;
`endif
            end
          end else begin
            // ce has no effect while idle.
            state_r <= IDLE;
            count_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
          end
        end

        RUN: begin
          if (abort) begin
            // Silent stop: no done pulse.
            state_r <= IDLE;
            count_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
          end else if (start) begin
            // Restart; a coincident ce is deliberately not counted.
            if (load_zero_s) begin
              state_r <= IDLE;
              count_r <= {WIDTH{1'b0}};
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
              count_r <= load_val;
              busy_r  <= 1'b1;
`ifdef TIMEOUT_TIMER_PERIODIC_EN
              reload_r <= load_val;
`endif
            end
          end else if (ce) begin
            if (last_tick_s) begin
              // Terminal tick: signal expiry.
              done_r <= 1'b1;
`ifdef TIMEOUT_TIMER_PERIODIC_EN
              state_r <= RUN;
              count_r <= reload_r;
              busy_r  <= 1'b1;
`else
              state_r <= IDLE;
              count_r <= {WIDTH{1'b0}};
              busy_r  <= 1'b0;
`endif
            end else if (count_r == {WIDTH{1'b0}}) begin
              // Unreachable in normal operation; recover to IDLE rather
              // than wrapping below zero.
              state_r <= IDLE;
              count_r <= {WIDTH{1'b0}};
              busy_r  <= 1'b0;
            end else begin
              state_r <= RUN;
              count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
              busy_r  <= 1'b1;
            end
          end else begin
            // No tick this cycle: hold the count.
            state_r <= RUN;
            count_r <= count_r;
            busy_r  <= 1'b1;
          end
        end

        default: begin
          // Illegal state encoding: return to a safe idle.
          state_r <= IDLE;
          count_r <= {WIDTH{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy      = busy_r;
    done      = done_r;
    remaining = count_r;
  end

endmodule

// File: tb/tb_timeout_timer.sv
// Directed self-checking bench for timeout_timer (WIDTH = 8).
// Inputs change 1 time unit after each rising edge; outputs are checked
// at the same point, i.e. reflecting the edge just taken.
module tb_timeout_timer;

  logic       clk;
  logic       clr;
  logic       ce;
  logic       start;
  logic [7:0] load_val;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  logic [9:0] obs;
  int checks;
  int failures;

  timeout_timer #(.WIDTH(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .ce        (ce),
    .start     (start),
    .load_val  (load_val),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {busy, done, remaining};

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; ce = 1'b0; start = 1'b0; abort = 1'b0; load_val = 8'd0;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    idle_inputs();
    clr = 1'b1;
    step();
    e = {1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_init got %h exp %h", obs, e);
    end
    // Count down to 5, then clear mid-countdown.
    clr = 1'b0; start = 1'b1; load_val = 8'd10;
    step();
    start = 1'b0; ce = 1'b1;
    for (int i = 0; i < 5; i++) step();
    e = {1'b1, 1'b0, 8'd5};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_pre got %h exp %h", obs, e);
    end
    clr = 1'b1;
    step();
    e = {1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_mid got %h exp %h", obs, e);
    end
    clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_quiet[%0d] got %h exp %h", i, obs, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_oneshot();
    logic [9:0] exp_t [5];
    exp_t[0] = {1'b1, 1'b0, 8'd3};
    exp_t[1] = {1'b1, 1'b0, 8'd2};
    exp_t[2] = {1'b1, 1'b0, 8'd1};
    exp_t[3] = {1'b0, 1'b1, 8'd0};
    exp_t[4] = {1'b0, 1'b0, 8'd0};
    idle_inputs();
    ce = 1'b1; start = 1'b1; load_val = 8'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
      checks++;
      if (obs !== exp_t[i]) begin
        failures++;
        $display("FAIL oneshot[%0d] got %h exp %h", i, obs, exp_t[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_sparse();
    logic       ce_t  [9];
    logic [9:0] exp_t [9];
    // Edge 0: start with a coincident ce (not counted); then ce every 4th.
    ce_t[0] = 1'b1; exp_t[0] = {1'b1, 1'b0, 8'd2};
    ce_t[1] = 1'b0; exp_t[1] = {1'b1, 1'b0, 8'd2};
    ce_t[2] = 1'b0; exp_t[2] = {1'b1, 1'b0, 8'd2};
    ce_t[3] = 1'b0; exp_t[3] = {1'b1, 1'b0, 8'd2};
    ce_t[4] = 1'b1; exp_t[4] = {1'b1, 1'b0, 8'd1};
    ce_t[5] = 1'b0; exp_t[5] = {1'b1, 1'b0, 8'd1};
    ce_t[6] = 1'b0; exp_t[6] = {1'b1, 1'b0, 8'd1};
    ce_t[7] = 1'b0; exp_t[7] = {1'b1, 1'b0, 8'd1};
    ce_t[8] = 1'b1; exp_t[8] = {1'b0, 1'b1, 8'd0};
    idle_inputs();
    start = 1'b1; load_val = 8'd2;
    for (int i = 0; i < 9; i++) begin
      ce = ce_t[i];
      step();
      start = 1'b0;
      checks++;
      if (obs !== exp_t[i]) begin
        failures++;
        $display("FAIL sparse[%0d] got %h exp %h", i, obs, exp_t[i]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_abort();
    logic [9:0] e;
    idle_inputs();
    start = 1'b1; load_val = 8'd10; ce = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    e = {1'b1, 1'b0, 8'd4};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL abort_pre got %h exp %h", obs, e);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    e = {1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL abort got %h exp %h", obs, e);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort_quiet[%0d] got %h exp %h", i, obs, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_restart();
    logic [9:0] e;
    idle_inputs();
    start = 1'b1; load_val = 8'd10; ce = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    start = 1'b1; load_val = 8'd7;
    step();
    start = 1'b0;
    e = {1'b1, 1'b0, 8'd7};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL restart got %h exp %h", obs, e);
    end
    step();
    e = {1'b1, 1'b0, 8'd6};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL restart_dec got %h exp %h", obs, e);
    end
    for (int i = 0; i < 6; i++) step();
    e = {1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL restart_done got %h exp %h", obs, e);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_zero_load();
    logic [9:0] e;
    idle_inputs();
    start = 1'b1; load_val = 8'd0; ce = 1'b1;
    step();
    start = 1'b0;
    e = {1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL zero_done got %h exp %h", obs, e);
    end
    step();
    e = {1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL zero_after got %h exp %h", obs, e);
    end
    // Zero-load restart while running acts as expiry.
    start = 1'b1; load_val = 8'd5;
    step();
    load_val = 8'd0;
    step();
    start = 1'b0;
    e = {1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL zero_restart got %h exp %h", obs, e);
    end
    idle_inputs();
    step();
  endtask

`ifdef TIMEOUT_TIMER_PERIODIC_EN
  task automatic test_periodic();
    logic [9:0] exp_t [8];
    exp_t[0] = {1'b1, 1'b0, 8'd2};
    exp_t[1] = {1'b1, 1'b0, 8'd1};
    exp_t[2] = {1'b1, 1'b1, 8'd2};
    exp_t[3] = {1'b1, 1'b0, 8'd1};
    exp_t[4] = {1'b1, 1'b1, 8'd2};
    exp_t[5] = {1'b1, 1'b0, 8'd1};
    exp_t[6] = {1'b0, 1'b0, 8'd0};
    exp_t[7] = {1'b0, 1'b0, 8'd0};
    idle_inputs();
    start = 1'b1; load_val = 8'd2; ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      abort = (i == 6) ? 1'b1 : 1'b0;
      step();
      start = 1'b0;
      checks++;
      if (obs !== exp_t[i]) begin
        failures++;
        $display("FAIL periodic[%0d] got %h exp %h", i, obs, exp_t[i]);
      end
    end
    idle_inputs();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    clr = 1'b1;
    test_reset();
    test_oneshot();
    test_sparse();
    test_abort();
    test_restart();
    test_zero_load();
`ifdef TIMEOUT_TIMER_PERIODIC_EN
    test_periodic();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
